// File: rtl/acc_pipe_cpu.sv
// acc_pipe_cpu: three-stage fetch/decode/execute accumulator core.
// Internal data memory with a host preload port; external instruction port.
module acc_pipe_cpu #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [ADDR_W+4:0]   imem_rdata,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic [DATA_W-1:0]   acc,
  output logic                e,
  output logic                halted,
  output logic                illegal,
  output logic                retired
);

  localparam int IW    = ADDR_W + 5;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [IW-1:0]     f_ir_q, f_ir_d;
  logic              f_v_q, f_v_d;
  logic [IW-1:0]     d_ir_q, d_ir_d;
  logic              d_v_q, d_v_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              e_q, e_d;
  logic              skip_q, skip_d;
  logic              halted_q, halted_d;
  logic              illegal_q, illegal_d;
  logic              retired_q, retired_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  logic              adv;
  logic              exec;
  logic              x_i;
  logic [3:0]        x_op;
  logic [ADDR_W-1:0] x_a;
  logic [3:0]        um;
  logic [ADDR_W-1:0] ea;
  logic [DATA_W-1:0] dr;
  logic [DATA_W:0]   add_r;
  logic [DATA_W:0]   sub_r;
  logic [DATA_W-1:0] isz_r;

  assign imem_addr = pc_q;
  assign dm_rdata  = mem_q[dm_addr];
  assign acc       = acc_q;
  assign e         = e_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign retired   = retired_q;

  // Pipeline advance, execute-stage datapath and memory write select
  always_comb begin
    adv   = run && !halted_q && !rst;
    exec  = adv && d_v_q && !skip_q;
    x_i   = d_ir_q[IW-1];
    x_op  = d_ir_q[IW-2:ADDR_W];
    x_a   = d_ir_q[ADDR_W-1:0];
    um    = x_a[3:0];
    ea    = x_i ? ADDR_W'(mem_q[x_a]) : x_a;
    dr    = mem_q[ea];
    add_r = {1'b0, acc_q} + {1'b0, dr};
    sub_r = {1'b0, acc_q} + {1'b0, ~dr} + (DATA_W+1)'(1);
    isz_r = dr + DATA_W'(1);

    pc_d      = pc_q;
    f_ir_d    = f_ir_q;
    f_v_d     = f_v_q;
    d_ir_d    = d_ir_q;
    d_v_d     = d_v_q;
    acc_d     = acc_q;
    e_d       = e_q;
    skip_d    = skip_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    retired_d = 1'b0;
    mem_we    = 1'b0;
    mem_wa    = ea;
    mem_wd    = acc_q;

    if (adv) begin
      pc_d   = pc_q + ADDR_W'(1);
      f_ir_d = imem_rdata;
      f_v_d  = 1'b1;
      d_ir_d = f_ir_q;
      d_v_d  = f_v_q;
      if (d_v_q && skip_q)
        skip_d = 1'b0;
    end

    if (exec) begin
      retired_d = 1'b1;
      unique case (1'b1)
        (x_op == 4'h0): acc_d = acc_q & dr;
        (x_op == 4'h1): acc_d = acc_q | dr;
        (x_op == 4'h2): acc_d = acc_q ^ dr;
        (x_op == 4'h3): {e_d, acc_d} = add_r;
        (x_op == 4'h4): {e_d, acc_d} = sub_r;
        (x_op == 4'h5): acc_d = dr;
        (x_op == 4'h6): mem_we = 1'b1;
        (x_op == 4'h7): begin
          mem_we = 1'b1;
          mem_wd = isz_r;
          if (isz_r == '0)
            skip_d = 1'b1;
        end
        (x_op == 4'h8): begin
          pc_d  = ea;
          f_v_d = 1'b0;
          d_v_d = 1'b0;
        end
        (x_op == 4'hF): begin
          unique case (1'b1)
            (um == 4'h0): acc_d = '0;
            (um == 4'h1): e_d = 1'b0;
            (um == 4'h2): acc_d = ~acc_q;
            (um == 4'h3): e_d = ~e_q;
            (um == 4'h4): begin
              acc_d = {e_q, acc_q[DATA_W-1:1]};
              e_d   = acc_q[0];
            end
            (um == 4'h5): begin
              acc_d = {acc_q[DATA_W-2:0], e_q};
              e_d   = acc_q[DATA_W-1];
            end
            (um == 4'h6): acc_d = acc_q + DATA_W'(1);
            (um == 4'h7): skip_d = !acc_q[DATA_W-1];
            (um == 4'h8): skip_d = acc_q[DATA_W-1];
            (um == 4'h9): skip_d = (acc_q == '0);
            (um == 4'hA): skip_d = !e_q;
            (um == 4'hB): begin
              halted_d = 1'b1;
              pc_d     = pc_q;
              f_v_d    = 1'b0;
              d_v_d    = 1'b0;
            end
            default: illegal_d = 1'b1;
          endcase
        end
        default: illegal_d = 1'b1;
      endcase
    end

    if (dm_we && !adv) begin
      mem_we = 1'b1;
      mem_wa = dm_addr;
      mem_wd = dm_wdata;
    end
  end

  // Architectural state and pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      f_ir_q    <= '0;
      f_v_q     <= 1'b0;
      d_ir_q    <= '0;
      d_v_q     <= 1'b0;
      acc_q     <= '0;
      e_q       <= 1'b0;
      skip_q    <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      f_ir_q    <= f_ir_d;
      f_v_q     <= f_v_d;
      d_ir_q    <= d_ir_d;
      d_v_q     <= d_v_d;
      acc_q     <= acc_d;
      e_q       <= e_d;
      skip_q    <= skip_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Data memory, deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we)
      mem_q[mem_wa] <= mem_wd;
  end

endmodule

// File: tb/tb_acc_pipe_cpu.sv
// tb_acc_pipe_cpu: directed tests for acc_pipe_cpu.
// Each task runs one program and checks final state inline.
module tb_acc_pipe_cpu;

  logic        clk;
  logic        rst;
  logic        run;
  logic [6:0]  imem_addr;
  logic [11:0] imem_rdata;
  logic        dm_we;
  logic [6:0]  dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata;
  logic [15:0] acc;
  logic        e;
  logic        halted;
  logic        illegal;
  logic        retired;

  logic [11:0] imem [128];
  int errors = 0;
  int checks = 0;

  int edges, rets, first_ret, stall_ret;

  assign imem_rdata = imem[imem_addr];

  acc_pipe_cpu #(.DATA_W(16), .ADDR_W(7)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .acc(acc), .e(e), .halted(halted),
    .illegal(illegal), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] mr(
    input logic i, input logic [3:0] op, input logic [6:0] a);
    return {i, op, a};
  endfunction

  function automatic logic [11:0] rr(input logic [3:0] u);
    return {1'b0, 4'hF, 3'b000, u};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    dm_we = 1'b0;
    dm_addr = '0;
    dm_wdata = '0;
    for (int i = 0; i < 128; i++) imem[i] = rr(4'hB);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic host_wr(input logic [6:0] a, input logic [15:0] d);
    @(negedge clk);
    dm_we = 1'b1;
    dm_addr = a;
    dm_wdata = d;
    @(negedge clk);
    dm_we = 1'b0;
  endtask

  task automatic host_rd(input logic [6:0] a, output logic [15:0] d);
    dm_addr = a;
    #1;
    d = dm_rdata;
  endtask

  task automatic run_prog(input int stall_after);
    edges = 0;
    rets = 0;
    first_ret = 0;
    stall_ret = 0;
    @(negedge clk);
    run = 1'b1;
    while (edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
      if (retired) begin
        rets++;
        if (first_ret == 0) first_ret = edges;
      end
      if (halted) break;
      if (edges == stall_after) begin
        run = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1;
          if (retired) stall_ret++;
        end
        run = 1'b1;
      end
    end
    run = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (acc !== 16'h0 || e !== 1'b0) begin
      errors++;
      $display("FAIL reset_acc_e: got acc=%h e=%b want 0000 0", acc, e);
    end
    checks++;
    if (halted !== 1'b0 || illegal !== 1'b0 || retired !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got h=%b i=%b r=%b want 0 0 0",
               halted, illegal, retired);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (imem_addr !== 7'h0) begin
      errors++;
      $display("FAIL reset_stall_pc: got %h want 00", imem_addr);
    end
  endtask

  task automatic test_basic();
    do_reset();
    imem[0] = mr(1'b0, 4'h5, 7'd3);
    imem[1] = mr(1'b0, 4'h3, 7'd4);
    imem[2] = rr(4'hB);
    host_wr(7'd3, 16'hFFFF);
    host_wr(7'd4, 16'h0002);
    run_prog(0);
    checks++;
    if (halted !== 1'b1 || edges !== 5) begin
      errors++;
      $display("FAIL basic_halt_edge: got h=%b edge=%0d want 1 5", halted, edges);
    end
    checks++;
    if (first_ret !== 3) begin
      errors++;
      $display("FAIL basic_first_retire: got %0d want 3", first_ret);
    end
    checks++;
    if (rets !== 3) begin
      errors++;
      $display("FAIL basic_retires: got %0d want 3", rets);
    end
    checks++;
    if (acc !== 16'h0001 || e !== 1'b1 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL basic_state: got acc=%h e=%b il=%b want 0001 1 0",
               acc, e, illegal);
    end
  endtask

  task automatic test_sub();
    logic [15:0] d;
    do_reset();
    imem[0] = mr(1'b0, 4'h5, 7'd3);
    imem[1] = mr(1'b0, 4'h4, 7'd4);
    imem[2] = mr(1'b0, 4'h6, 7'd9);
    imem[3] = mr(1'b0, 4'h5, 7'd4);
    imem[4] = mr(1'b0, 4'h4, 7'd3);
    imem[5] = rr(4'hB);
    host_wr(7'd3, 16'h0005);
    host_wr(7'd4, 16'h0007);
    run_prog(0);
    host_rd(7'd9, d);
    checks++;
    if (d !== 16'hFFFE) begin
      errors++;
      $display("FAIL sub_borrow: got mem9=%h want fffe", d);
    end
    checks++;
    if (acc !== 16'h0002 || e !== 1'b1 || halted !== 1'b1) begin
      errors++;
      $display("FAIL sub_noborrow: got acc=%h e=%b h=%b want 0002 1 1",
               acc, e, halted);
    end
  endtask

  task automatic test_skip();
    do_reset();
    imem[0] = rr(4'h0);
    imem[1] = rr(4'h9);
    imem[2] = rr(4'h6);
    imem[3] = rr(4'h6);
    imem[4] = rr(4'hB);
    run_prog(0);
    checks++;
    if (acc !== 16'h0001 || rets !== 4 || halted !== 1'b1) begin
      errors++;
      $display("FAIL skip_sza: got acc=%h ret=%0d h=%b want 0001 4 1",
               acc, rets, halted);
    end
  endtask

  task automatic test_isz();
    logic [15:0] d;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      imem[0] = mr(1'b0, 4'h7, 7'd10);
      imem[1] = rr(4'h6);
      imem[2] = rr(4'hB);
      host_wr(7'd10, (k == 0) ? 16'hFFFF : 16'h0005);
      run_prog(0);
      host_rd(7'd10, d);
      checks++;
      if (d !== ((k == 0) ? 16'h0000 : 16'h0006)) begin
        errors++;
        $display("FAIL isz_mem%0d: got %h want %h", k, d,
                 (k == 0) ? 16'h0000 : 16'h0006);
      end
      checks++;
      if (acc !== ((k == 0) ? 16'h0000 : 16'h0001) ||
          rets !== ((k == 0) ? 2 : 3)) begin
        errors++;
        $display("FAIL isz_acc%0d: got acc=%h ret=%0d", k, acc, rets);
      end
    end
  endtask

  task automatic test_indirect();
    logic [15:0] d;
    do_reset();
    imem[0] = mr(1'b1, 4'h5, 7'd2);
    imem[1] = mr(1'b0, 4'h6, 7'd5);
    imem[2] = rr(4'h2);
    imem[3] = mr(1'b1, 4'h6, 7'd2);
    imem[4] = rr(4'hB);
    host_wr(7'd2, 16'h0020);
    host_wr(7'h20, 16'h1234);
    host_wr(7'd5, 16'h0000);
    run_prog(0);
    host_rd(7'd5, d);
    checks++;
    if (d !== 16'h1234) begin
      errors++;
      $display("FAIL ind_lda: got %h want 1234", d);
    end
    host_rd(7'h20, d);
    checks++;
    if (d !== 16'hEDCB || acc !== 16'hEDCB) begin
      errors++;
      $display("FAIL ind_sta: got mem=%h acc=%h want edcb edcb", d, acc);
    end
  endtask

  task automatic test_jmp();
    do_reset();
    imem[0]    = mr(1'b0, 4'h8, 7'h40);
    imem[1]    = rr(4'h6);
    imem[2]    = rr(4'h6);
    imem[7'h40] = rr(4'h6);
    imem[7'h41] = mr(1'b0, 4'h9, 7'h0);
    imem[7'h42] = rr(4'hB);
    run_prog(0);
    checks++;
    if (edges !== 8 || rets !== 4 || halted !== 1'b1) begin
      errors++;
      $display("FAIL jmp_timing: got edge=%0d ret=%0d want 8 4", edges, rets);
    end
    checks++;
    if (acc !== 16'h0001 || illegal !== 1'b1) begin
      errors++;
      $display("FAIL jmp_illegal: got acc=%h il=%b want 0001 1", acc, illegal);
    end
    run = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run = 1'b0;
    checks++;
    if (imem_addr !== 7'h44 || retired !== 1'b0) begin
      errors++;
      $display("FAIL halt_freeze: got pc=%h r=%b want 44 0", imem_addr, retired);
    end
  endtask

  task automatic test_rotate(input int stall_after);
    logic [15:0] d;
    do_reset();
    imem[0] = mr(1'b0, 4'h5, 7'd7);
    imem[1] = rr(4'h1);
    imem[2] = rr(4'h5);
    imem[3] = mr(1'b0, 4'h6, 7'd8);
    imem[4] = rr(4'h4);
    imem[5] = rr(4'hB);
    host_wr(7'd7, 16'h8000);
    host_wr(7'd8, 16'h5555);
    run_prog(stall_after);
    host_rd(7'd8, d);
    checks++;
    if (d !== 16'h0000) begin
      errors++;
      $display("FAIL cil_%0d: got mem8=%h want 0000", stall_after, d);
    end
    checks++;
    if (acc !== 16'h8000 || e !== 1'b0 || rets !== 6 || edges !== 8) begin
      errors++;
      $display("FAIL cir_%0d: got acc=%h e=%b ret=%0d edge=%0d want 8000 0 6 8",
               stall_after, acc, e, rets, edges);
    end
    checks++;
    if (stall_ret !== 0) begin
      errors++;
      $display("FAIL stall_retire: got %0d want 0", stall_ret);
    end
  endtask

  task automatic test_host_gate();
    logic [15:0] d;
    do_reset();
    host_wr(7'd12, 16'hAAAA);
    imem[0] = rr(4'h6);
    imem[1] = rr(4'h6);
    @(negedge clk);
    run = 1'b1;
    dm_we = 1'b1;
    dm_addr = 7'd12;
    dm_wdata = 16'h1111;
    @(negedge clk);
    dm_we = 1'b0;
    run = 1'b0;
    host_rd(7'd12, d);
    checks++;
    if (d !== 16'hAAAA) begin
      errors++;
      $display("FAIL host_gate: got %h want aaaa", d);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sub();
    test_skip();
    test_isz();
    test_indirect();
    test_jmp();
    test_rotate(0);
    test_rotate(4);
    test_host_gate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
